// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-wide data-memory access sequencer.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } dm_state_e;

  // Access length in bytes; only ctrl[1:0] matters for legal encodings.
  function automatic logic [2:0] dm_len(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   dm_len = 3'd1;
      2'b01:   dm_len = 3'd2;
      default: dm_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_extend.sv
// Combinational sign/zero extension of the assembled big-endian load value.
module dm_load_extend
  import dm_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [2:0]  ctrl,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = acc;
    case (ctrl)
      DM_B:    rdata = {{24{acc[7]}}, acc[7:0]};
      DM_H:    rdata = {{16{acc[15]}}, acc[15:0]};
      DM_BU:   rdata = {24'b0, acc[7:0]};
      DM_HU:   rdata = {16'b0, acc[15:0]};
      default: rdata = acc;
    endcase
  end

endmodule

// File: rtl/dm_access_sequencer.sv
// Sequences B/H/W loads and stores onto a byte-wide memory, one byte per clock, big-endian.
// Define DM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module dm_access_sequencer
  import dm_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_ctrl,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  dm_state_e         state_q, state_d;
  logic              wr_q, wr_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       acc_q, acc_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;

  logic [2:0]  len;
  logic [2:0]  pos_full;
  logic [1:0]  pos;
  logic [31:0] wdata_sh;
  logic [31:0] ext_rdata;
  logic        req_err;
  logic        misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      ctrl_q  <= 3'b0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      acc_q   <= 32'b0;
      idx_q   <= 2'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

`ifdef DM_ALIGN_CHECK_EN
  assign misalign = (req_ctrl[1:0] == 2'b01 && req_addr[0]) ||
                    (req_ctrl[1:0] == 2'b10 && (|req_addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_ctrl == 3'b011) || (req_ctrl == 3'b110) || (req_ctrl == 3'b111) ||
                   (req_wr && req_ctrl[2]) || (|req_addr[31:ADDR_W]) || misalign;

  // Byte lane for this beat: beat 0 carries the most significant byte.
  assign len      = dm_len(ctrl_q);
  assign pos_full = len - 3'd1 - {1'b0, idx_q};
  assign pos      = pos_full[1:0];
  assign wdata_sh = wdata_q >> {pos, 3'b000};

  dm_load_extend u_ext (
    .acc   (acc_q),
    .ctrl  (ctrl_q),
    .rdata (ext_rdata)
  );

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'b0;
    rsp_err   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          wr_d    = req_wr;
          ctrl_d  = req_ctrl;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          acc_d   = 32'b0;
          idx_d   = 2'b0;
          err_d   = req_err;
          state_d = req_err ? RESP : XFER;
        end
      end
      XFER: begin
        // Address arithmetic truncates to ADDR_W, so wrap-around is free.
        mem_addr = addr_q + {{(ADDR_W-2){1'b0}}, idx_q};
        if (wr_q) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_sh[7:0];
        end else begin
          acc_d = acc_q | ({24'b0, mem_rdata} << {pos, 3'b000});
        end
        idx_d = idx_q + 2'd1;
        if ({1'b0, idx_q} == len - 3'd1) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || wr_q) ? 32'b0 : ext_rdata;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_access_sequencer.sv
// Scoreboard bench for dm_access_sequencer with a behavioural 64-byte memory.
module tb_dm_access_sequencer;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [2:0]        req_ctrl = 3'b0;
  logic [31:0]       req_addr = 32'b0;
  logic [31:0]       req_wdata = 32'b0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0] mem [0:63];
  int cyc = 0;
  int we_cnt = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  dm_access_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;
  assign mem_rdata = mem[mem_addr];

  task automatic do_req(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input string name);
    int   acc_cyc;
    bit   seen;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    acc_cyc = cyc;
    sb.push_back('{exp_rd, exp_err, exp_lat});
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 1'b0; req_wdata = 32'hDEAD_BEEF; req_addr = 32'h0000_003C;
      end
      if (rsp_valid) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: rsp_valid not seen within 20 cycles", name);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata) begin
      errors++; $display("FAIL %s_rdata: got %h expected %h", name, rsp_rdata, e.rdata);
    end
    checks++;
    if (rsp_err !== e.err) begin
      errors++; $display("FAIL %s_err: got %b expected %b", name, rsp_err, e.err);
    end
    checks++;
    if (cyc - acc_cyc !== e.lat) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc - acc_cyc, e.lat);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_pulse: rsp_valid=%b req_ready=%b expected 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic check_mem(input int a, input logic [7:0] exp, input string name);
    checks++;
    if (mem[a] !== exp) begin
      errors++; $display("FAIL %s: DM[%0h]=%h expected %h", name, a, mem[a], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_we !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'b0 || mem_addr !== '0 || mem_wdata !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b vld=%b we=%b err=%b rdata=%h addr=%h expected all 0",
               req_ready, rsp_valid, mem_we, rsp_err, rsp_rdata, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_sw_lw();
    do_req(1'b1, 3'b010, 32'h10, 32'h8001_7FFF, 32'h0, 1'b0, 5, "sw");
    check_mem(8'h10, 8'h80, "sw_b0");
    check_mem(8'h11, 8'h01, "sw_b1");
    check_mem(8'h12, 8'h7F, "sw_b2");
    check_mem(8'h13, 8'hFF, "sw_b3");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001_7FFF, 1'b0, 5, "lw");
    do_req(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_8001, 1'b0, 3, "lh");
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_7FFF, 1'b0, 3, "lhu");
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'h0000_7FFF, 1'b0, 3, "lh_pos");
  endtask

  task automatic test_byte_ext();
    do_req(1'b1, 3'b000, 32'h20, 32'h1234_56F0, 32'h0, 1'b0, 2, "sb");
    check_mem(8'h20, 8'hF0, "sb_byte");
    do_req(1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, "lb");
    do_req(1'b0, 3'b100, 32'h20, 32'h0, 32'h0000_00F0, 1'b0, 2, "lbu");
  endtask

  task automatic test_wrap();
`ifdef DM_ALIGN_CHECK_EN
    do_req(1'b1, 3'b001, 32'h3F, 32'h0000_1234, 32'h0, 1'b1, 1, "sh_wrap_misalign");
    do_req(1'b1, 3'b001, 32'h3E, 32'h0000_1234, 32'h0, 1'b0, 3, "sh_3e");
    check_mem(8'h3E, 8'h12, "sh_3e_hi");
    check_mem(8'h3F, 8'h34, "sh_3e_lo");
    do_req(1'b0, 3'b101, 32'h3E, 32'h0, 32'h0000_1234, 1'b0, 3, "lhu_3e");
`else
    do_req(1'b1, 3'b001, 32'h3F, 32'hFFFF_1234, 32'h0, 1'b0, 3, "sh_wrap");
    check_mem(8'h3F, 8'h12, "sh_wrap_hi");
    check_mem(8'h00, 8'h34, "sh_wrap_lo");
    do_req(1'b0, 3'b101, 32'h3F, 32'h0, 32'h0000_1234, 1'b0, 3, "lhu_wrap");
    do_req(1'b0, 3'b010, 32'h3E, 32'h0, 32'h0012_3400, 1'b0, 5, "lw_wrap");
`endif
  endtask

  task automatic test_errors();
    int we0;
    we0 = we_cnt;
    do_req(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1, "err_ctrl110");
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "err_ctrl011");
    do_req(1'b0, 3'b000, 32'h40, 32'h0, 32'h0, 1'b1, 1, "err_addr40");
    do_req(1'b1, 3'b100, 32'h08, 32'hAA, 32'h0, 1'b1, 1, "err_sbu");
    do_req(1'b1, 3'b010, 32'h8000_0010, 32'h5555_5555, 32'h0, 1'b1, 1, "err_addr_hi");
    checks++;
    if (we_cnt !== we0) begin
      errors++; $display("FAIL err_no_write: mem_we pulses got %0d expected 0", we_cnt - we0);
    end
    check_mem(8'h10, 8'h80, "err_mem_intact");
  endtask

  task automatic test_align();
`ifdef DM_ALIGN_CHECK_EN
    do_req(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 1, "lw_misalign");
`else
    do_req(1'b0, 3'b010, 32'h12, 32'h0, 32'h7FFF_0000, 1'b0, 5, "lw_misalign");
`endif
    do_req(1'b1, 3'b010, 32'h04, 32'hCAFE_F00D, 32'h0, 1'b0, 5, "sw_04");
    do_req(1'b0, 3'b010, 32'h04, 32'h0, 32'hCAFE_F00D, 1'b0, 5, "lw_04");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [5:0] a;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      a = 6'(8 + $urandom_range(0, 7));
      do_req(1'b1, 3'b000, {26'b0, a}, {24'hABCDEF, d}, 32'h0, 1'b0, 2, "b2b_sb");
      do_req(1'b0, 3'b000, {26'b0, a}, 32'h0, {{24{d[7]}}, d}, 1'b0, 2, "b2b_lb");
      do_req(1'b0, 3'b100, {26'b0, a}, 32'h0, {24'b0, d}, 1'b0, 2, "b2b_lbu");
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    do_req(1'b1, 3'b010, 32'h30, 32'h1122_3344, 32'h0, 1'b0, 5, "rst_pre");
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_ctrl = 3'b010; req_addr = 32'h30;
    req_wdata = 32'hA1B2_C3D4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: mem_we=%b req_ready=%b expected 0/0", mem_we, req_ready);
    end
    got = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    checks++;
    if (got) begin
      errors++; $display("FAIL rst_mid_rsp: rsp_valid seen=1 expected 0");
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready);
    end
    check_mem(8'h30, 8'hA1, "rst_mid_b0");
    check_mem(8'h31, 8'hB2, "rst_mid_b1");
    check_mem(8'h32, 8'h33, "rst_mid_b2");
    check_mem(8'h33, 8'h44, "rst_mid_b3");
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 32'hA1B2_3344, 1'b0, 5, "rst_mid_lw");
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte_ext();
    test_wrap();
    test_errors();
    test_align();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
